// File: rtl/dispatch_router_pkg.sv
// Shared types, op-format constants and the class-to-channel map for the dispatch stage.
package dispatch_router_pkg;

  localparam int unsigned RENAMED_OP_SZ = 64;

  // Class field location inside a renamed op.
  localparam int unsigned CLASS_LSB = 45;
  localparam int unsigned CLASS_W   = 3;

  // Terminator class; always routed to the last channel.
  localparam logic [CLASS_W-1:0] CLASS_TERM = 3'b111;

  typedef enum logic {
    StHalt = 1'b0,
    StRun  = 1'b1
  } disp_state_e;

  // Legal codes are the direct channels 0..num_classes-2 plus the terminator code.
  function automatic logic class_is_legal(input logic [CLASS_W-1:0] code,
                                          input int unsigned        num_classes);
    return (code == CLASS_TERM) || (32'(code) < num_classes - 1);
  endfunction

  // Illegal codes fall back to channel 0.
  function automatic int unsigned class_to_chan(input logic [CLASS_W-1:0] code,
                                                input int unsigned        num_classes);
    if (code == CLASS_TERM) begin
      return num_classes - 1;
    end else if (32'(code) < num_classes - 1) begin
      return 32'(code);
    end else begin
      return 0;
    end
  endfunction

endpackage

// File: rtl/dispatch_router_alloc.sv
// Oldest-first lane allocator: walks pending slots in program order, hands out lanes
// per channel up to the clipped space, stops at the first slot that cannot go, and
// drops everything younger than a dispatched terminator.
module dispatch_alloc #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned NUM_CLASSES = 3,
  parameter int unsigned PUSH_WIDTH  = 2,
  parameter int unsigned CW          = 2,
  parameter int unsigned SW          = 2,
  parameter int unsigned LW          = 1
) (
  input  logic [FETCH_WIDTH-1:0]                pending_i,
  input  logic [FETCH_WIDTH-1:0][CW-1:0]        slot_chan_i,
  input  logic [NUM_CLASSES-1:0][SW-1:0]        space_i,
  output logic [FETCH_WIDTH-1:0]                disp_o,
  output logic [FETCH_WIDTH-1:0][LW-1:0]        lane_o,
  output logic [FETCH_WIDTH-1:0]                drop_o,
  output logic                                  term_hit_o
);

  logic [NUM_CLASSES-1:0][SW-1:0] used;
  logic                           blocked;
  logic                           term_seen;

  // Sequential walk from slot 0; 'used' counts lanes already granted per channel.
  always_comb begin
    used      = '0;
    blocked   = 1'b0;
    term_seen = 1'b0;
    disp_o    = '0;
    lane_o    = '0;
    drop_o    = '0;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      if (pending_i[i]) begin
        if (term_seen) begin
          drop_o[i] = 1'b1;
        end else if (!blocked) begin
          if (used[slot_chan_i[i]] < space_i[slot_chan_i[i]]) begin
            disp_o[i]              = 1'b1;
            lane_o[i]              = LW'(used[slot_chan_i[i]]);
            used[slot_chan_i[i]]   = used[slot_chan_i[i]] + SW'(1);
            if (slot_chan_i[i] == CW'(NUM_CLASSES - 1)) begin
              term_seen = 1'b1;
            end
          end else begin
            blocked = 1'b1;
          end
        end
      end
    end
    term_hit_o = term_seen;
  end

endmodule

// File: rtl/dispatch_router.sv
// In-order dispatch stage: routes up to FETCH_WIDTH renamed ops per cycle into
// NUM_CLASSES issue channels, holds partially dispatched bundles, and halts after
// a terminator op until woken.
module dispatch_router
  import dispatch_router_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH   = 4,
  parameter int unsigned NUM_CLASSES   = 3,
  parameter int unsigned PUSH_WIDTH    = 2,
  parameter int unsigned OP_W          = RENAMED_OP_SZ,
  parameter bit          START_RUNNING = 1'b1,
  localparam int unsigned SW           = $clog2(PUSH_WIDTH + 1),
  localparam int unsigned DCW          = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wakeup,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH*OP_W-1:0]            in_ops,
  input  logic [FETCH_WIDTH-1:0]                 in_valid,
  output logic                                   in_ready,
  input  logic                                   alias_ready,
  input  logic [NUM_CLASSES*SW-1:0]              out_space,
  output logic [NUM_CLASSES*PUSH_WIDTH*OP_W-1:0] out_ops,
  output logic [NUM_CLASSES*PUSH_WIDTH-1:0]      out_valid,
  output logic [DCW-1:0]                         disp_count,
  output logic                                   class_err
);

  localparam int unsigned CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned LW = (PUSH_WIDTH > 1) ? $clog2(PUSH_WIDTH) : 1;

  disp_state_e state_q, state_d;
  logic [FETCH_WIDTH-1:0] done_mask_q, done_mask_d;
  logic                   class_err_q, class_err_d;

  logic [FETCH_WIDTH-1:0][CW-1:0] slot_chan;
  logic [FETCH_WIDTH-1:0]         slot_illegal;
  logic [NUM_CLASSES-1:0][SW-1:0] space_clip;
  logic                           enable;
  logic [FETCH_WIDTH-1:0]         pending;
  logic [FETCH_WIDTH-1:0]         disp;
  logic [FETCH_WIDTH-1:0][LW-1:0] slot_lane;
  logic [FETCH_WIDTH-1:0]         drop;
  logic                           term_hit;

  // Decode each slot's class field into a channel and clip advertised space.
  always_comb begin
    slot_chan    = '0;
    slot_illegal = '0;
    space_clip   = '0;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      slot_chan[i]    = CW'(class_to_chan(in_ops[i*OP_W + CLASS_LSB +: CLASS_W], NUM_CLASSES));
      slot_illegal[i] = !class_is_legal(in_ops[i*OP_W + CLASS_LSB +: CLASS_W], NUM_CLASSES);
    end
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      if (out_space[c*SW +: SW] > SW'(PUSH_WIDTH)) begin
        space_clip[c] = SW'(PUSH_WIDTH);
      end else begin
        space_clip[c] = out_space[c*SW +: SW];
      end
    end
  end

  // Dispatch gating: only undispatched valid slots are offered, and only when enabled.
  always_comb begin
    enable  = !rst && !flush && alias_ready && ((state_q == StRun) || wakeup);
    pending = in_valid & ~done_mask_q & {FETCH_WIDTH{enable}};
  end

  dispatch_alloc #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .NUM_CLASSES (NUM_CLASSES),
    .PUSH_WIDTH  (PUSH_WIDTH),
    .CW          (CW),
    .SW          (SW),
    .LW          (LW)
  ) u_alloc (
    .pending_i   (pending),
    .slot_chan_i (slot_chan),
    .space_i     (space_clip),
    .disp_o      (disp),
    .lane_o      (slot_lane),
    .drop_o      (drop),
    .term_hit_o  (term_hit)
  );

  // State register, done mask and sticky class error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= START_RUNNING ? StRun : StHalt;
      done_mask_q <= '0;
      class_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_mask_q <= done_mask_d;
      class_err_q <= class_err_d;
    end
  end

  // Next state: flush wins, alias stall freezes, terminator beats wakeup.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StHalt;
    end else if (alias_ready) begin
      if (term_hit) begin
        state_d = StHalt;
      end else if (wakeup) begin
        state_d = StRun;
      end
    end
  end

  // Done-mask and error bookkeeping; an empty bundle leaves the mask alone.
  always_comb begin
    if (flush) begin
      done_mask_d = '0;
    end else if (in_ready && (|in_valid)) begin
      done_mask_d = '0;
    end else begin
      done_mask_d = done_mask_q | disp;
    end
    class_err_d = class_err_q | (|(disp & slot_illegal));
  end

  // Outputs: lane muxing, ROB allocation count and bundle-consumed handshake.
  always_comb begin
    out_valid  = '0;
    out_ops    = '0;
    disp_count = '0;
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      for (int l = 0; l < int'(PUSH_WIDTH); l++) begin
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
          if (disp[i] && (slot_chan[i] == CW'(c)) && (slot_lane[i] == LW'(l))) begin
            out_valid[c*PUSH_WIDTH + l]                 = 1'b1;
            out_ops[(c*PUSH_WIDTH + l)*OP_W +: OP_W]    = in_ops[i*OP_W +: OP_W];
          end
        end
      end
    end
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      disp_count = disp_count + DCW'(disp[i]);
    end
    in_ready = (!rst && flush) ||
               (enable && ((in_valid & ~(done_mask_q | disp | drop)) == '0));
  end

  assign class_err = class_err_q;

endmodule

// File: tb/tb_dispatch_router.sv
// Scoreboard bench for dispatch_router: each step pushes the expected lane map,
// handshake and count, then pops and compares on the falling clock edge.
module tb_dispatch_router;
  import dispatch_router_pkg::*;

  localparam int unsigned FW  = 4;
  localparam int unsigned NC  = 3;
  localparam int unsigned PW  = 2;
  localparam int unsigned OW  = RENAMED_OP_SZ;
  localparam int unsigned SW  = $clog2(PW + 1);
  localparam int unsigned DCW = $clog2(FW + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wakeup;
  logic                   flush;
  logic [FW*OW-1:0]       in_ops;
  logic [FW-1:0]          in_valid;
  logic                   in_ready;
  logic                   alias_ready;
  logic [NC*SW-1:0]       out_space;
  logic [NC*PW*OW-1:0]    out_ops;
  logic [NC*PW-1:0]       out_valid;
  logic [DCW-1:0]         disp_count;
  logic                   class_err;

  always #5 clk = ~clk;

  dispatch_router #(
    .FETCH_WIDTH   (FW),
    .NUM_CLASSES   (NC),
    .PUSH_WIDTH    (PW),
    .OP_W          (OW),
    .START_RUNNING (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wakeup      (wakeup),
    .flush       (flush),
    .in_ops      (in_ops),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alias_ready (alias_ready),
    .out_space   (out_space),
    .out_ops     (out_ops),
    .out_valid   (out_valid),
    .disp_count  (disp_count),
    .class_err   (class_err)
  );

  typedef struct {
    logic [NC*PW-1:0]    valid;
    logic [NC*PW*OW-1:0] ops;
    logic                ready;
    logic [DCW-1:0]      count;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  // Random payload per slot with the class code planted in its field.
  task automatic set_bundle(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                            input logic [2:0] c3, input logic [FW-1:0] v);
    logic [2:0]    cls[FW];
    logic [OW-1:0] op;
    cls = '{c0, c1, c2, c3};
    for (int i = 0; i < int'(FW); i++) begin
      op = OW'({$urandom, $urandom});
      op[CLASS_LSB +: CLASS_W] = cls[i];
      in_ops[i*OW +: OW] = op;
    end
    in_valid = v;
  endtask

  task automatic set_space(input int s0, input int s1, input int s2);
    out_space = {SW'(s2), SW'(s1), SW'(s0)};
  endtask

  // Lane arguments name the bundle slot expected on ch0l0, ch0l1, ch1l0, ch1l1, ch2l0, ch2l1.
  task automatic expect_out(input int l00, input int l01, input int l10, input int l11,
                            input int l20, input int l21, input logic rdy, input int cnt);
    exp_t e;
    int   lanes[NC*PW];
    lanes   = '{l00, l01, l10, l11, l20, l21};
    e.valid = '0;
    e.ops   = '0;
    for (int k = 0; k < int'(NC*PW); k++) begin
      if (lanes[k] >= 0) begin
        e.valid[k]          = 1'b1;
        e.ops[k*OW +: OW]   = in_ops[lanes[k]*OW +: OW];
      end
    end
    e.ready = rdy;
    e.count = DCW'(cnt);
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t                e;
    logic [NC*PW*OW-1:0] mask;
    @(negedge clk);
    check_eq("sb_depth", 512'(sb_q.size() != 0), 512'(1));
    if (sb_q.size() != 0) begin
      e    = sb_q.pop_front();
      mask = '0;
      for (int k = 0; k < int'(NC*PW); k++) begin
        if (e.valid[k]) mask[k*OW +: OW] = '1;
      end
      check_eq("out_valid",  512'(out_valid),      512'(e.valid));
      check_eq("out_ops",    512'(out_ops & mask), 512'(e.ops));
      check_eq("in_ready",   512'(in_ready),       512'(e.ready));
      check_eq("disp_count", 512'(disp_count),     512'(e.count));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    wakeup      = 1'b0;
    flush       = 1'b0;
    alias_ready = 1'b1;
    set_space(2, 2, 2);
    set_bundle(3'd0, 3'd1, 3'd0, 3'd1, 4'hF);

    phase = "reset";
    expect_out(-1, -1, -1, -1, -1, -1, 1'b0, 0); step();
    expect_out(-1, -1, -1, -1, -1, -1, 1'b0, 0); step();
    check_eq("class_err_rst", 512'(class_err), 512'(0));
    rst = 1'b0;

    phase = "full_bundle";
    expect_out(0, 2, 1, 3, -1, -1, 1'b1, 4); step();

    phase = "empty_bundle";
    in_valid = '0;
    expect_out(-1, -1, -1, -1, -1, -1, 1'b1, 0); step();

    // ch0 advertises 3 but is clipped to 2 lanes.
    phase = "excess_slip";
    set_space(3, 2, 2);
    set_bundle(3'd0, 3'd0, 3'd0, 3'd1, 4'hF);
    expect_out(0, 1, -1, -1, -1, -1, 1'b0, 2); step();
    expect_out(2, -1, 3, -1, -1, -1, 1'b1, 2); step();
    set_space(2, 2, 2);

    phase = "terminator";
    set_bundle(3'd1, 3'd7, 3'd0, 3'd0, 4'hF);
    expect_out(-1, -1, 0, -1, 1, -1, 1'b1, 2); step();
    set_bundle(3'd0, 3'd1, 3'd0, 3'd1, 4'hF);
    expect_out(-1, -1, -1, -1, -1, -1, 1'b0, 0); step();
    expect_out(-1, -1, -1, -1, -1, -1, 1'b0, 0); step();
    wakeup = 1'b1;
    expect_out(0, 2, 1, 3, -1, -1, 1'b1, 4); step();
    wakeup = 1'b0;

    phase = "zero_space";
    set_space(0, 2, 2);
    set_bundle(3'd1, 3'd0, 3'd1, 3'd1, 4'hF);
    expect_out(-1, -1, 0, -1, -1, -1, 1'b0, 1); step();
    set_space(1, 2, 2);
    expect_out(1, -1, 2, 3, -1, -1, 1'b1, 3); step();
    set_space(2, 2, 2);

    phase = "alias_stall";
    set_bundle(3'd0, 3'd0, 3'd0, 3'd1, 4'hF);
    expect_out(0, 1, -1, -1, -1, -1, 1'b0, 2); step();
    alias_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      expect_out(-1, -1, -1, -1, -1, -1, 1'b0, 0); step();
    end
    alias_ready = 1'b1;
    expect_out(2, -1, 3, -1, -1, -1, 1'b1, 2); step();

    phase = "flush";
    set_bundle(3'd0, 3'd0, 3'd0, 3'd1, 4'hF);
    expect_out(0, 1, -1, -1, -1, -1, 1'b0, 2); step();
    alias_ready = 1'b0;
    expect_out(-1, -1, -1, -1, -1, -1, 1'b0, 0); step();
    flush = 1'b1;
    expect_out(-1, -1, -1, -1, -1, -1, 1'b1, 0); step();
    flush       = 1'b0;
    alias_ready = 1'b1;
    expect_out(-1, -1, -1, -1, -1, -1, 1'b0, 0); step();
    wakeup = 1'b1;
    expect_out(0, 1, -1, -1, -1, -1, 1'b0, 2); step();
    wakeup = 1'b0;
    expect_out(2, -1, 3, -1, -1, -1, 1'b1, 2); step();

    phase = "class_err";
    set_bundle(3'd3, 3'd1, 3'd0, 3'd0, 4'b0011);
    check_eq("class_err_pre", 512'(class_err), 512'(0));
    expect_out(0, -1, 1, -1, -1, -1, 1'b1, 2); step();
    check_eq("class_err_set", 512'(class_err), 512'(1));
    set_bundle(3'd0, 3'd1, 3'd0, 3'd1, 4'hF);
    expect_out(0, 2, 1, 3, -1, -1, 1'b1, 4); step();
    check_eq("class_err_sticky", 512'(class_err), 512'(1));
    rst = 1'b1;
    expect_out(-1, -1, -1, -1, -1, -1, 1'b0, 0); step();
    rst = 1'b0;
    check_eq("class_err_clear", 512'(class_err), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
